// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO write-side logic.
package fifo_pkg;

  localparam logic [7:0] DEFAULT_PAD_VALUE = 8'h00;

  // Width of a lane index for a word of `ratio` lanes.
  function automatic int lane_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Legal packer geometry: word is exactly ratio lanes, ratio a power of two >= 2.
  function automatic bit widths_ok(input int in_w, input int ratio, input int data_w);
    return (data_w == in_w * ratio) && (ratio >= 2) && ((ratio & (ratio - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_write_packer.sv
// Packs a narrow lane stream LSB-first into FIFO words and issues write
// strobes gated by the FIFO's registered almost-full flag.
module fifo_write_packer
  import fifo_pkg::*;
#(
  parameter int                  IN_WIDTH   = 8,
  parameter int                  RATIO      = 2,
  parameter int                  DATA_WIDTH = 16,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE  = IN_WIDTH'(DEFAULT_PAD_VALUE)
) (
  input  logic                  I_write_clk,
  input  logic                  I_write_rst_n,
  input  logic                  I_in_valid,
  output logic                  O_in_ready,
  input  logic [IN_WIDTH-1:0]   I_in_data,
  input  logic                  I_in_last,
  input  logic                  I_flush,
  input  logic                  I_write_full,
  output logic                  O_cmd_write,
  output logic [DATA_WIDTH-1:0] O_write_data,
  output logic [15:0]           O_pkt_count
);

  localparam int LW = lane_idx_w(RATIO);

  if (!widths_ok(IN_WIDTH, RATIO, DATA_WIDTH)) begin : g_bad_cfg
    $error("fifo_write_packer: DATA_WIDTH must equal IN_WIDTH*RATIO with RATIO a power of two >= 2");
  end

  logic [LW-1:0]         lane_cnt;
  logic [LW:0]           filled;
  logic [DATA_WIDTH-1:0] asm_data, asm_nxt, close_word, hold_data;
  logic                  hold_valid, hold_last, hold_free;
  logic                  accept, close_possible, lane_close, close;
  logic [15:0]           pkt_count;

  assign O_cmd_write  = hold_valid & ~I_write_full;
  assign O_write_data = hold_data;
  assign O_pkt_count  = pkt_count;

  // Holding register can take a new word this cycle (empty or draining).
  assign hold_free = ~hold_valid | O_cmd_write;

  // A close would happen if a lane were accepted now; built without I_in_valid
  // so ready has no combinational dependence on valid.
  assign close_possible = (lane_cnt == LW'(RATIO - 1)) | I_in_last | I_flush;
  assign O_in_ready     = I_write_rst_n & (hold_free | ~close_possible);
  assign accept         = I_in_valid & O_in_ready;

  // Lanes present in the word after this cycle's accept.
  assign filled     = {1'b0, lane_cnt} + (LW + 1)'(accept);
  assign lane_close = accept & ((lane_cnt == LW'(RATIO - 1)) | I_in_last);
  // A flush only closes when the holding register can take the word; while it
  // is blocked the level flush simply waits.
  assign close      = lane_close | (hold_free & I_flush & (filled != '0));

  // Merge the accepted lane and build the padded word a close would emit.
  always_comb begin
    asm_nxt    = asm_data;
    close_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (accept && (lane_cnt == LW'(i)))
        asm_nxt[i*IN_WIDTH +: IN_WIDTH] = I_in_data;
      close_word[i*IN_WIDTH +: IN_WIDTH] =
        ((LW + 1)'(i) < filled) ? asm_nxt[i*IN_WIDTH +: IN_WIDTH] : PAD_VALUE;
    end
  end

  // Lane assembly and the single-entry holding register.
  always_ff @(posedge I_write_clk or negedge I_write_rst_n) begin
    if (!I_write_rst_n) begin
      lane_cnt   <= '0;
      asm_data   <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
    end else begin
      if (close) begin
        lane_cnt <= '0;
        asm_data <= '0;
      end else if (accept) begin
        lane_cnt <= lane_cnt + LW'(1);
        asm_data <= asm_nxt;
      end
      if (close) begin
        hold_valid <= 1'b1;
        hold_data  <= close_word;
        hold_last  <= accept & I_in_last;
      end else if (O_cmd_write) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Count written words that ended a packet; wraps naturally.
  always_ff @(posedge I_write_clk or negedge I_write_rst_n) begin
    if (!I_write_rst_n)
      pkt_count <= '0;
    else if (O_cmd_write && hold_last)
      pkt_count <= pkt_count + 16'd1;
  end

endmodule

// File: tb/tb_fifo_write_packer.sv
// Bench for fifo_write_packer: directed cases with literal expectations plus
// randomized traffic checked cycle-by-cycle against a queue-based model.
module tb_fifo_write_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // RATIO=2 instance
  logic        in_valid = 0, in_last = 0, flush = 0, full = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, cmd_write;
  logic [15:0] wdata, pkt;

  // RATIO=4 instance
  logic        v4 = 0, l4 = 0;
  logic [7:0]  d4 = 0;
  logic        rdy4, cmd4;
  logic [31:0] wd4;
  logic [15:0] pkt4;

  fifo_write_packer #(.IN_WIDTH(8), .RATIO(2), .DATA_WIDTH(16)) u2 (
    .I_write_clk(clk), .I_write_rst_n(rst_n),
    .I_in_valid(in_valid), .O_in_ready(in_ready), .I_in_data(in_data),
    .I_in_last(in_last), .I_flush(flush), .I_write_full(full),
    .O_cmd_write(cmd_write), .O_write_data(wdata), .O_pkt_count(pkt)
  );

  fifo_write_packer #(.IN_WIDTH(8), .RATIO(4), .DATA_WIDTH(32)) u4 (
    .I_write_clk(clk), .I_write_rst_n(rst_n),
    .I_in_valid(v4), .O_in_ready(rdy4), .I_in_data(d4),
    .I_in_last(l4), .I_flush(1'b0), .I_write_full(1'b0),
    .O_cmd_write(cmd4), .O_write_data(wd4), .O_pkt_count(pkt4)
  );

  int nchk = 0, nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model (RATIO=2) ----------------
  typedef struct { logic [15:0] d; logic last; } wd_t;
  logic [7:0]  cur[$];     // lanes of the word under construction
  wd_t         exp_q[$];   // closed words not yet written
  int          mpkt = 0;
  logic [15:0] wr_log[$];
  logic [31:0] log4[$];
  bit          in_rst = 1;
  bit          m_hold, m_cmd, m_cp, m_rdy;

  task automatic model_close(input bit l);
    wd_t w;
    w.d = '0;
    for (int i = 0; i < 2; i++) w.d[i*8 +: 8] = (i < cur.size()) ? cur[i] : 8'h00;
    w.last = l;
    exp_q.push_back(w);
    cur.delete();
  endtask

  // Compare process: outputs sampled mid-low-phase, model advanced per cycle.
  always @(negedge clk) begin
    #2;
    if (!in_rst) begin
      m_hold = exp_q.size() > 0;
      m_cmd  = m_hold && !full;
      m_cp   = (cur.size() == 1) || in_last || flush;
      m_rdy  = !(m_hold && !m_cmd && m_cp);
      chk("cmd_write", cmd_write, m_cmd);
      chk("in_ready", in_ready, m_rdy);
      chk("pkt_count", pkt, mpkt);
      if (cmd_write && full) chk("write_while_full", cmd_write, 0);
      if (cmd_write && m_hold) begin
        chk("write_data", wdata, exp_q[0].d);
        wr_log.push_back(wdata);
        if (exp_q[0].last) mpkt = (mpkt + 1) & 16'hFFFF;
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        if (cur.size() == 2 || in_last) model_close(in_last);
      end
      if (flush && in_ready && cur.size() > 0) model_close(1'b0);
    end
  end

  always @(negedge clk) begin
    #2;
    if (!in_rst && cmd4) log4.push_back(wd4);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0; in_last = 0; flush = 0;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int b;
    b = 0;
    @(negedge clk);
    in_valid = 1; in_data = d; in_last = l; flush = 0;
    #1;
    while (!in_ready && b < 50) begin
      @(negedge clk); #1; b++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
  endtask

  task automatic model_reset();
    cur.delete(); exp_q.delete(); mpkt = 0;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_cmd", cmd_write, 0);
    chk("rst_data", wdata, 0);
    chk("rst_pkt", pkt, 0);
    chk("rst_cmd4", cmd4, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1; in_rst = 0;

    // RATIO=4: 01..04 then 05(last)
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      v4 = 1; d4 = 8'(i); l4 = (i == 5);
      #1 chk("r4_ready", rdy4, 1);
    end
    @(negedge clk); v4 = 0; l4 = 0;
    repeat (4) @(negedge clk);
    chk("r4_nwrites", log4.size(), 2);
    chk("r4_word0", log4[0], 32'h04030201);
    chk("r4_word1", log4[1], 32'h00000005);
    chk("r4_pkt", pkt4, 1);

    // back-to-back 11,22,33,44
    wr_log.delete();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    idle(4);
    chk("b2b_nwrites", wr_log.size(), 2);
    chk("b2b_word0", wr_log[0], 16'h2211);
    chk("b2b_word1", wr_log[1], 16'h4433);

    // odd packet 11,22,AA(last)
    wr_log.delete();
    send(8'h11, 0); send(8'h22, 0); send(8'hAA, 1);
    idle(4);
    chk("odd_word0", wr_log[0], 16'h2211);
    chk("odd_word1", wr_log[1], 16'h00AA);
    chk("odd_pkt", pkt, 1);

    // full held while offering 4 lanes
    wr_log.delete();
    @(negedge clk); full = 1;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    @(negedge clk);
    in_valid = 1; in_data = 8'h44; in_last = 0;
    #1;
    chk("full_ready_drop", in_ready, 0);
    chk("full_no_write", cmd_write, 0);
    repeat (3) @(negedge clk);
    #1 chk("full_still_blocked", in_ready, 0);
    chk("full_nwrites_held", wr_log.size(), 0);
    full = 0;
    #1 chk("full_release_ready", in_ready, 1);
    idle(4);
    chk("full_nwrites", wr_log.size(), 2);
    chk("full_word0", wr_log[0], 16'h2211);
    chk("full_word1", wr_log[1], 16'h4433);

    // flush pulses
    wr_log.delete();
    @(negedge clk); flush = 1;
    idle(3);
    chk("flush_empty_nowrite", wr_log.size(), 0);
    send(8'h5A, 0);
    @(negedge clk); in_valid = 0; flush = 1;
    idle(3);
    chk("flush_nwrites", wr_log.size(), 1);
    chk("flush_word", wr_log[0], 16'h005A);
    chk("flush_pkt", pkt, 1);

    // reset after a lone lane
    send(8'h77, 0);
    idle(1);
    @(negedge clk);
    in_rst = 1; rst_n = 0;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_cmd", cmd_write, 0);
    chk("mid_rst_data", wdata, 0);
    chk("mid_rst_pkt", pkt, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1; in_rst = 0;
    wr_log.delete();
    send(8'h01, 0); send(8'h02, 0);
    idle(3);
    chk("post_rst_nwrites", wr_log.size(), 1);
    chk("post_rst_word", wr_log[0], 16'h0201);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid = ($urandom % 100) < 70;
      in_data  = 8'($urandom);
      in_last  = ($urandom % 100) < 10;
      flush    = ($urandom % 100) < 8;
      full     = ($urandom % 100) < 30;
    end
    @(negedge clk);
    full = 0; in_valid = 0; in_last = 0; flush = 1;
    repeat (4) @(negedge clk);
    idle(3);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_no_partial", cur.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
